// File: rtl/mux_input_stage_if.sv
// mux_input_stage_if
//   Bundles the raw board inputs and the registered mux-side outputs of
//   mux_input_stage.
//   master: board / stimulus side; drives switches and buttons, reads results.
//   slave : mux_input_stage itself; reads raw inputs, drives X, Y, s, upd.
//   Signals:
//     sw_x, sw_y    raw operand switches (asynchronous)
//     btn_load      raw LOAD button, active-high, bouncy
//     btn_sel       raw SEL button, active-high, bouncy
//     X, Y          registered operands to the mux
//     s             registered select (0 picks X, 1 picks Y)
//     upd           one-cycle strobe when X/Y/s take new values
interface mux_input_stage_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_x;
    logic [WIDTH-1:0] sw_y;
    logic             btn_load;
    logic             btn_sel;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             s;
    logic             upd;

    modport master (
        output sw_x, sw_y, btn_load, btn_sel,
        input  X, Y, s, upd
    );

    modport slave (
        input  sw_x, sw_y, btn_load, btn_sel,
        output X, Y, s, upd
    );
endinterface

// File: rtl/mux_input_stage.sv
// mux_input_stage
//   Front end for the 4-bit 2-to-1 mux. Synchronises raw switches and
//   buttons, debounces LOAD and SEL, captures the operands on a LOAD press,
//   toggles the select on a SEL press and strobes upd for one cycle whenever
//   an action is taken.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mux_input_stage_if.slave (sw_x, sw_y, btn_load, btn_sel in;
//            X, Y, s, upd out)
//
//   Debounce FSM (one per button):
//     state     | meaning
//     S_IDLE    | button released and accepted as released
//     S_ARM     | high samples being counted towards a press
//     S_PRESSED | press accepted, action already issued
//     S_REL     | low samples being counted towards a release
module mux_input_stage #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_input_stage_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_REL     = 2'd3;

    // Count value at which the next qualifying sample completes the run.
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sx_pipe;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sy_pipe;
    logic [SYNC_STAGES-1:0]            r_lb_pipe;
    logic [SYNC_STAGES-1:0]            r_sb_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx_pipe <= '0;
            r_sy_pipe <= '0;
            r_lb_pipe <= '0;
            r_sb_pipe <= '0;
        end else begin
            r_sx_pipe[0] <= bus.sw_x;
            r_sy_pipe[0] <= bus.sw_y;
            r_lb_pipe[0] <= bus.btn_load;
            r_sb_pipe[0] <= bus.btn_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sx_pipe[i] <= r_sx_pipe[i-1];
                r_sy_pipe[i] <= r_sy_pipe[i-1];
                r_lb_pipe[i] <= r_lb_pipe[i-1];
                r_sb_pipe[i] <= r_sb_pipe[i-1];
            end
        end
    end

    logic [WIDTH-1:0] w_sx;
    logic [WIDTH-1:0] w_sy;
    logic [1:0]       w_btn;   // [0] LOAD, [1] SEL

    assign w_sx  = r_sx_pipe[SYNC_STAGES-1];
    assign w_sy  = r_sy_pipe[SYNC_STAGES-1];
    assign w_btn = {r_sb_pipe[SYNC_STAGES-1], r_lb_pipe[SYNC_STAGES-1]};

    // ------------------------------------------------------------------
    // Debounce FSMs, index 0 = LOAD, index 1 = SEL
    // ------------------------------------------------------------------
    logic [1:0]    r_state [2];
    logic [CW-1:0] r_cnt   [2];
    logic [1:0]    r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= S_IDLE;
                r_cnt[b]   <= '0;
            end
            r_press <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_press[b] <= 1'b0;
                case (r_state[b])
                    S_IDLE: begin
                        if (w_btn[b]) begin
                            r_state[b] <= S_ARM;
                            r_cnt[b]   <= C_ONE;
                        end
                    end
                    S_ARM: begin
                        if (!w_btn[b]) begin
                            r_state[b] <= S_IDLE;
                            r_cnt[b]   <= '0;
                        end else if (r_cnt[b] == C_LAST) begin
                            // Press accepted; the action fires exactly once here.
                            r_state[b] <= S_PRESSED;
                            r_cnt[b]   <= '0;
                            r_press[b] <= 1'b1;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + 1'b1;
                        end
                    end
                    S_PRESSED: begin
                        if (!w_btn[b]) begin
                            r_state[b] <= S_REL;
                            r_cnt[b]   <= C_ONE;
                        end
                    end
                    S_REL: begin
                        if (w_btn[b]) begin
                            r_state[b] <= S_PRESSED;
                            r_cnt[b]   <= '0;
                        end else if (r_cnt[b] == C_LAST) begin
                            r_state[b] <= S_IDLE;
                            r_cnt[b]   <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + 1'b1;
                        end
                    end
                    default: begin
                        r_state[b] <= S_IDLE;
                        r_cnt[b]   <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_s;
    logic             r_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_s   <= 1'b0;
            r_upd <= 1'b0;
        end else begin
            // A simultaneous LOAD and SEL still produce a single strobe.
            r_upd <= |r_press;
            if (r_press[0]) begin
                r_x <= w_sx;
                r_y <= w_sy;
            end
            if (r_press[1]) begin
                r_s <= ~r_s;
            end
        end
    end

    assign bus.X   = r_x;
    assign bus.Y   = r_y;
    assign bus.s   = r_s;
    assign bus.upd = r_upd;

endmodule
